aes_table_dec: RTL and testbench
================================

Name: aes_table_dec

Overview:
Iterative AES-128 decryption core. It is the inverse counterpart of the team's table-S-box encryption core and uses the same Kin/Din/Krdy/Drdy/Kvld/Dvld/EN/BSY handshake. It computes one round per enabled clock.
- On key load it runs the forward key expansion to derive round key K10.
- During decryption it regenerates K9..K0 on the fly with the inverse key schedule.
- It sits beside the encryption core in the crypto target, behind the same host interface.

Parameters:
NR, 10, number of AES rounds (fixed for AES-128; listed for documentation only, no other value supported)

Ports:
CLK  in  1  system clock, all registers on rising edge
rst  in  1  reset, asynchronous, active-high
EN  in  1  global enable; when 0 every register holds its value
Kin  in  128  cipher key, byte 0 at [127:120]
Din  in  128  ciphertext input
Dout  out  128  plaintext output (state register)
Krdy  in  1  key-load strobe, 1 cycle
Drdy  in  1  data-start strobe, 1 cycle
Kvld  out  1  1-cycle pulse when K10 is ready
Dvld  out  1  1-cycle pulse when Dout holds plaintext
BSY  out  1  high while key expansion or decryption is in progress

Behaviour:
- Reset values:
  - State = IDLE.
  - Dout/state register = 0; key, rkey and lastkey = 0.
  - Kvld = Dvld = BSY = 0.
  - key_ok = 0. key_ok is an internal flag meaning "a valid key has been expanded".
- All behaviour below applies only on edges where EN = 1.
- FSM states: IDLE, KEXP, DEC. A 4-bit round counter rc is used.
- Krdy has priority in every state:
  - Effects: key <= Kin, rkey <= Kin, rcon <= 0x01, rc <= 0, key_ok <= 0, state <= KEXP, BSY <= 1.
  - Krdy during DEC aborts the decryption; no Dvld is produced.
- KEXP:
  - Each edge: rkey <= forward expansion of rkey with rcon; rcon <= xtime(rcon); rc++.
  - Forward expansion: w0 = k0 ^ SubWord(RotWord(k3)) ^ {rcon,24'h0}; w1 = w0^k1; w2 = w1^k2; w3 = w2^k3.
  - On the 10th expansion edge (rc == 9): lastkey <= result, key_ok <= 1, Kvld <= 1 for one cycle, state <= IDLE, BSY <= 0.
  - Latency: Kvld is high in the cycle after the 10th edge following Krdy.
- IDLE:
  - Drdy with key_ok = 1: dat <= Din ^ lastkey; rkey <= lastkey; rcon <= 0x36; rc <= 0; state <= DEC; BSY <= 1.
  - Drdy with key_ok = 0: ignored; all outputs unchanged.
- DEC, each edge:
  - Inverse key step:
    - k3' = k3^k2; k2' = k2^k1; k1' = k1^k0.
    - k0' = k0 ^ SubWord(RotWord(k3')) ^ {rcon,24'h0}.
    - rkey <= next key.
    - rcon <= inv_xtime(rcon), where inv_xtime(x) = x[0] ? ((x^0x1B)>>1)|0x80 : x>>1.
  - Round on dat uses the newly derived key as the round key:
    - t = InvSubBytes(InvShiftRows(dat)) ^ key.
    - rc < 9: dat <= InvMixColumns(t).
    - rc == 9: dat <= t (final round, no InvMixColumns).
  - rc++.
  - On the rc == 9 edge: Dvld <= 1 for one cycle, state <= IDLE, BSY <= 0.
  - Drdy in DEC or KEXP is ignored (not queued).
- Timing:
  - Drdy edge = t0. Rounds occur on t1..t10. Dvld is high in the cycle after t10.
  - Dout holds the plaintext until the next Drdy or Krdy.
- Back-to-back: Drdy is accepted in the same cycle Dvld is high (state is IDLE).
- Kvld and Dvld self-clear after one cycle.
- If EN drops mid-operation, the operation pauses and resumes with no loss.

Decomposition:
- Package aes_dec_pkg:
  - Constants: RCON_FIRST = 8'h01, RCON_LAST = 8'h36, NR = 10.
  - State enum {IDLE, KEXP, DEC}.
  - Functions xtime, inv_xtime, InvMixColumns column function.
- Sub-module aes_inv_sbox: 32-bit-wide inverse S-box, 4 instances in the data path.
- The existing forward SubBytes module is reused for the key schedule.

Test Plan:
- rst, then Krdy with Kin = 000102030405060708090a0b0c0d0e0f -> Kvld pulse exactly 11 cycles after the Krdy edge; internal lastkey = 13111d7fe3944a17f307a78b4d2b30c5; BSY high for 10 cycles.
- Same key; Drdy with Din = 69c4e0d86a7b0430d8cdb78070b4c55a -> Dvld 11 cycles later; Dout = 00112233445566778899aabbccddeeff.
- Key 2b7e151628aed2a6abf7158809cf4f3c (lastkey d014f9a8c9ee2589e13f0cc8b6630ca6); Din = 3925841d02dc09fbdc118597196a0b32 -> Dout = 3243f6a8885a308d313198a2e0370734; a second Drdy issued in the Dvld cycle produces the same result again.
- Drdy after rst with no key loaded -> no BSY, no Dvld, Dout stays 0. Drdy during KEXP -> ignored.
- Krdy at DEC round 5 -> no Dvld pulse; new Kvld after 11 cycles; a following decryption gives the correct plaintext. Toggling EN low for 3 cycles mid-DEC delays Dvld by exactly 3 cycles.
- Assert rst mid-DEC -> all outputs 0 immediately (asynchronous); key_ok = 0, so a subsequent Drdy is ignored.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-128
// decryption core and its S-box sub-modules.
package aes_dec_pkg;

  localparam int         NR         = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Divide by x modulo the AES polynomial (steps rcon backwards).
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  // General GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] fwd_sbox_byte(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the field inverse.
  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // InvMixColumns on one column, top byte is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Row r moves right by r columns; byte (r,c) sits at index r + 4c from the top.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse SubBytes on a 32-bit word (one state column per instance).
module aes_inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign dout[8*i +: 8] = inv_sbox_byte(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward SubBytes on a 32-bit word, used by the key schedule.
module aes_sbox
  import aes_dec_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign dout[8*i +: 8] = fwd_sbox_byte(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_table_dec.sv
// Iterative AES-128 decryption core, one round per enabled clock.
// A key load runs the forward schedule to K10; decryption then walks the
// schedule backwards, deriving each round key in the same cycle it is used.
module aes_table_dec
  import aes_dec_pkg::*;
(
  input  logic         CLK,
  input  logic         rst,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic [127:0] Din,
  output logic [127:0] Dout,
  input  logic         Krdy,
  input  logic         Drdy,
  output logic         Kvld,
  output logic         Dvld,
  output logic         BSY
);

  localparam logic [3:0] LAST_RC = 4'(NR - 1);

  state_t       state, state_next;
  logic [3:0]   rc, rc_next;
  logic [7:0]   rcon, rcon_next;
  logic [127:0] key, key_next;
  logic [127:0] rkey, rkey_next;
  logic [127:0] lastkey, lastkey_next;
  logic [127:0] dat, dat_next;
  logic         key_ok, key_ok_next;
  logic         kvld, kvld_next;
  logic         dvld, dvld_next;
  logic         bsy, bsy_next;

  logic [127:0] exp_src, fwd_key, inv_key;
  logic [127:0] isr, isb, rnd_t, rnd_mix;
  logic [31:0]  sw_in, sw_out;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  k0_inv, k1_inv, k2_inv, k3_inv;

  // ---------------- key schedule (one shared SubWord) ----------------
  // The first expansion step reads the freshly latched cipher key.
  assign exp_src = (rc == 4'd0) ? key : rkey;

  assign k3_inv = rkey[31:0]   ^ rkey[63:32];
  assign k2_inv = rkey[63:32]  ^ rkey[95:64];
  assign k1_inv = rkey[95:64]  ^ rkey[127:96];

  assign sw_in = (state == DEC) ? k3_inv : exp_src[31:0];

  aes_sbox u_key_sbox (
    .din  ({sw_in[23:0], sw_in[31:24]}),
    .dout (sw_out)
  );

  assign w0 = exp_src[127:96] ^ sw_out ^ {rcon, 24'h000000};
  assign w1 = w0 ^ exp_src[95:64];
  assign w2 = w1 ^ exp_src[63:32];
  assign w3 = w2 ^ exp_src[31:0];
  assign fwd_key = {w0, w1, w2, w3};

  assign k0_inv  = rkey[127:96] ^ sw_out ^ {rcon, 24'h000000};
  assign inv_key = {k0_inv, k1_inv, k2_inv, k3_inv};

  // ---------------- round data path ----------------
  assign isr = inv_shift_rows(dat);

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_sbox u_inv_sbox (
      .din  (isr[127 - 32*c -: 32]),
      .dout (isb[127 - 32*c -: 32])
    );
    assign rnd_mix[127 - 32*c -: 32] = inv_mix_col(rnd_t[127 - 32*c -: 32]);
  end

  assign rnd_t = isb ^ inv_key;

  // State register; EN low freezes the sequencer.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (EN) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

  // Next-state: a key load wins over everything, otherwise run to rc == 9.
  always_comb begin
    state_next = state;
    if (Krdy) begin
      state_next = KEXP;
    end else begin
      case (state)
        IDLE:    state_next = (Drdy && key_ok) ? DEC : IDLE;
        KEXP:    state_next = (rc == LAST_RC) ? IDLE : KEXP;
        DEC:     state_next = (rc == LAST_RC) ? IDLE : DEC;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and flag updates for the coming edge; pulses default low.
  always_comb begin
    rc_next      = rc;
    rcon_next    = rcon;
    key_next     = key;
    rkey_next    = rkey;
    lastkey_next = lastkey;
    dat_next     = dat;
    key_ok_next  = key_ok;
    kvld_next    = 1'b0;
    dvld_next    = 1'b0;
    bsy_next     = bsy;
    if (Krdy) begin
      key_next    = Kin;
      rkey_next   = Kin;
      rcon_next   = RCON_FIRST;
      rc_next     = 4'd0;
      key_ok_next = 1'b0;
      bsy_next    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Drdy && key_ok) begin
            dat_next  = Din ^ lastkey;
            rkey_next = lastkey;
            rcon_next = RCON_LAST;
            rc_next   = 4'd0;
            bsy_next  = 1'b1;
          end else begin
            bsy_next  = bsy;
          end
        end
        KEXP: begin
          rkey_next = fwd_key;
          rcon_next = xtime(rcon);
          rc_next   = rc + 4'd1;
          if (rc == LAST_RC) begin
            lastkey_next = fwd_key;
            key_ok_next  = 1'b1;
            kvld_next    = 1'b1;
            bsy_next     = 1'b0;
          end else begin
            bsy_next     = 1'b1;
          end
        end
        DEC: begin
          rkey_next = inv_key;
          rcon_next = inv_xtime(rcon);
          rc_next   = rc + 4'd1;
          if (rc == LAST_RC) begin
            dat_next  = rnd_t;
            dvld_next = 1'b1;
            bsy_next  = 1'b0;
          end else begin
            dat_next  = rnd_mix;
            bsy_next  = 1'b1;
          end
        end
        default: begin
          bsy_next = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers, all held while EN is low.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rc      <= 4'd0;
      rcon    <= 8'h00;
      key     <= 128'h0;
      rkey    <= 128'h0;
      lastkey <= 128'h0;
      dat     <= 128'h0;
      key_ok  <= 1'b0;
      kvld    <= 1'b0;
      dvld    <= 1'b0;
      bsy     <= 1'b0;
    end else if (EN) begin
      rc      <= rc_next;
      rcon    <= rcon_next;
      key     <= key_next;
      rkey    <= rkey_next;
      lastkey <= lastkey_next;
      dat     <= dat_next;
      key_ok  <= key_ok_next;
      kvld    <= kvld_next;
      dvld    <= dvld_next;
      bsy     <= bsy_next;
    end else begin
      rc      <= rc;
      rcon    <= rcon;
      key     <= key;
      rkey    <= rkey;
      lastkey <= lastkey;
      dat     <= dat;
      key_ok  <= key_ok;
      kvld    <= kvld;
      dvld    <= dvld;
      bsy     <= bsy;
    end
  end

  assign Dout = dat;
  assign Kvld = kvld;
  assign Dvld = dvld;
  assign BSY  = bsy;

endmodule

// File: tb/tb_aes_table_dec.sv
// Self-checking bench for aes_table_dec: FIPS-197 vectors, handshake timing,
// abort/reset/enable corner cases and random keys/data against a byte-level
// AES-128 reference model.
module tb_aes_table_dec;

  logic         CLK;
  logic         rst;
  logic         EN;
  logic [127:0] Kin;
  logic [127:0] Din;
  logic [127:0] Dout;
  logic         Krdy;
  logic         Drdy;
  logic         Kvld;
  logic         Dvld;
  logic         BSY;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  sbox_m  [256];
  logic [7:0]  isbox_m [256];
  logic [7:0]  rcon_m  [10];
  logic [31:0] w_m     [44];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] L1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] L2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes_table_dec dut (
    .CLK  (CLK),
    .rst  (rst),
    .EN   (EN),
    .Kin  (Kin),
    .Din  (Din),
    .Dout (Dout),
    .Krdy (Krdy),
    .Drdy (Drdy),
    .Kvld (Kvld),
    .Dvld (Dvld),
    .BSY  (BSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box by walking the multiplicative group with generator 3.
  function automatic void build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_m[sbox_m[i]] = 8'(i);
    x = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon_m[i] = x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return r;
  endfunction

  // Full 44-word key expansion into w_m.
  function automatic void expand(input logic [127:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w_m[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_m[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4 - 1], 24'h000000};
      end
      w_m[i] = w_m[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] k10_m();
    return {w_m[40], w_m[41], w_m[42], w_m[43]};
  endfunction

  function automatic logic [7:0] rkbyte(input int r, input int i);
    logic [31:0] w;
    w = w_m[4*r + i/4];
    return w[31 - 8*(i%4) -: 8];
  endfunction

  // Textbook inverse cipher on a 16-byte array using the expanded key.
  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rkbyte(10, i);
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isbox_m[t[i]] ^ rkbyte(r, i);
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Krdy pulse; Kvld must appear on the 11th sample counting the Krdy edge as 1.
  task automatic load_key(input logic [127:0] k, input logic [127:0] exp_last,
                          input string tag, input bit poke_drdy);
    int got, bsy_cnt, kv_cnt, dv_cnt;
    got = 0; bsy_cnt = 0; kv_cnt = 0; dv_cnt = 0;
    Kin = k; Krdy = 1'b1;
    tick();
    Krdy = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (BSY) bsy_cnt++;
      if (Dvld) dv_cnt++;
      if (Kvld) begin
        kv_cnt++;
        if (got == 0) got = n;
      end
      if (poke_drdy && n == 4) begin
        Drdy = 1'b1; Din = CT1;
      end else begin
        Drdy = 1'b0;
      end
      tick();
    end
    check({tag, "_kvld_lat"}, 128'(got), 128'd11);
    check({tag, "_kvld_cnt"}, 128'(kv_cnt), 128'd1);
    check({tag, "_bsy_cycles"}, 128'(bsy_cnt), 128'd10);
    check({tag, "_no_dvld"}, 128'(dv_cnt), 128'd0);
    check({tag, "_lastkey"}, dut.lastkey, exp_last);
    check({tag, "_key_ok"}, 128'(dut.key_ok), 128'd1);
  endtask

  // Drdy pulse; optional EN gap starting after sample 5; optional back-to-back Drdy.
  task automatic run_dec(input logic [127:0] ct, input logic [127:0] pt, input string tag,
                         input int gap, input bit b2b);
    int got1, got2, dv, bsy_cnt;
    logic [127:0] d1, d2;
    got1 = 0; got2 = 0; dv = 0; bsy_cnt = 0; d1 = 128'h0; d2 = 128'h0;
    Din = ct; Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (BSY) bsy_cnt++;
      if (Dvld) begin
        dv++;
        if (got1 == 0) begin
          got1 = n; d1 = Dout;
        end else if (got2 == 0) begin
          got2 = n; d2 = Dout;
        end
      end
      EN   = (n >= 5 && n < 5 + gap) ? 1'b0 : 1'b1;
      Drdy = (b2b && n == got1) ? 1'b1 : 1'b0;
      tick();
    end
    EN = 1'b1;
    check({tag, "_dvld_lat"}, 128'(got1), 128'(11 + gap));
    check({tag, "_dout"}, d1, pt);
    check({tag, "_dvld_cnt"}, 128'(dv), b2b ? 128'd2 : 128'd1);
    check({tag, "_bsy_cycles"}, 128'(bsy_cnt), b2b ? 128'd20 : 128'(10 + gap));
    check({tag, "_dout_held"}, Dout, pt);
    if (b2b) begin
      check({tag, "_b2b_lat"}, 128'(got2), 128'd22);
      check({tag, "_b2b_dout"}, d2, pt);
    end
  endtask

  // Drdy while no key is valid: nothing may start.
  task automatic drdy_ignored(input string tag);
    int bsy_cnt, dv;
    bsy_cnt = 0; dv = 0;
    Din = {$urandom, $urandom, $urandom, $urandom};
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (BSY) bsy_cnt++;
      if (Dvld) dv++;
      tick();
    end
    check({tag, "_no_bsy"}, 128'(bsy_cnt), 128'd0);
    check({tag, "_no_dvld"}, 128'(dv), 128'd0);
    check({tag, "_dout_zero"}, Dout, 128'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] rk, rd, rexp;
    rst = 1'b1; EN = 1'b1; Kin = 128'h0; Din = 128'h0; Krdy = 1'b0; Drdy = 1'b0;
    build_tables();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dout", Dout, 128'h0);
    check("rst_kvld", 128'(Kvld), 128'd0);
    check("rst_dvld", 128'(Dvld), 128'd0);
    check("rst_bsy", 128'(BSY), 128'd0);
    check("rst_key_ok", 128'(dut.key_ok), 128'd0);
    rst = 1'b0;
    tick();

    drdy_ignored("nokey");

    // FIPS-197 appendix C.1, with a Drdy poked into the key expansion
    expand(K1);
    load_key(K1, L1, "k1", 1'b1);
    run_dec(CT1, PT1, "v1", 0, 1'b0);

    // FIPS-197 appendix B, then back-to-back and an EN pause
    expand(K2);
    load_key(K2, L2, "k2", 1'b0);
    run_dec(CT2, PT2, "v2", 0, 1'b1);
    run_dec(CT2, PT2, "v2_en", 3, 1'b0);

    // Krdy part-way through a decryption aborts it
    Din = CT2; Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    repeat (5) tick();
    expand(K1);
    load_key(K1, L1, "abort_k1", 1'b0);
    run_dec(CT1, PT1, "after_abort", 0, 1'b0);

    // random keys and ciphertexts against the model
    for (int j = 0; j < 3; j++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      expand(rk);
      load_key(rk, k10_m(), "rnd_key", 1'b0);
      for (int m = 0; m < 2; m++) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        rexp = model_dec(rd);
        run_dec(rd, rexp, "rnd_dec", (j == 1 && m == 1) ? 2 : 0, 1'b0);
      end
    end

    // asynchronous reset in the middle of a decryption
    Din = {$urandom, $urandom, $urandom, $urandom}; Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_dout", Dout, 128'h0);
    check("arst_bsy", 128'(BSY), 128'd0);
    check("arst_dvld", 128'(Dvld), 128'd0);
    check("arst_kvld", 128'(Kvld), 128'd0);
    check("arst_key_ok", 128'(dut.key_ok), 128'd0);
    check("arst_lastkey", dut.lastkey, 128'h0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    tick();
    drdy_ignored("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
